// File: rtl/id_stage_pkg.sv
// Shared decode constants for the RV32I ID stage: opcodes, control levels and immediate formats.
package id_stage_pkg;

  localparam logic RstEnable   = 1'b1;
  localparam logic WriteEnable = 1'b1;

  localparam int unsigned InstW = 32;
  localparam int unsigned OpcW  = 7;

  localparam logic [OpcW-1:0] OpcLui    = 7'b0110111;
  localparam logic [OpcW-1:0] OpcAuipc  = 7'b0010111;
  localparam logic [OpcW-1:0] OpcJal    = 7'b1101111;
  localparam logic [OpcW-1:0] OpcJalr   = 7'b1100111;
  localparam logic [OpcW-1:0] OpcBranch = 7'b1100011;
  localparam logic [OpcW-1:0] OpcLoad   = 7'b0000011;
  localparam logic [OpcW-1:0] OpcStore  = 7'b0100011;
  localparam logic [OpcW-1:0] OpcOpImm  = 7'b0010011;
  localparam logic [OpcW-1:0] OpcOp     = 7'b0110011;

  typedef enum logic [2:0] {
    FmtR,
    FmtI,
    FmtS,
    FmtB,
    FmtU,
    FmtJ
  } fmt_e;

endpackage

// File: rtl/id_stage_imm_gen.sv
// Immediate generator: assembles and sign-extends the immediate for each RV32I format.
module id_stage_imm_gen
  import id_stage_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [31:7]     inst_i,
  input  fmt_e            fmt_i,
  output logic [XLEN-1:0] imm_o
);

  logic [31:0] imm32;

  always_comb begin
    imm32 = '0;
    unique case (fmt_i)
      FmtI:    imm32 = {{20{inst_i[31]}}, inst_i[31:20]};
      FmtS:    imm32 = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
      FmtB:    imm32 = {{19{inst_i[31]}}, inst_i[31], inst_i[7], inst_i[30:25],
                        inst_i[11:8], 1'b0};
      FmtU:    imm32 = {inst_i[31:12], 12'b0};
      FmtJ:    imm32 = {{11{inst_i[31]}}, inst_i[31], inst_i[19:12], inst_i[20],
                        inst_i[30:21], 1'b0};
      default: imm32 = '0;
    endcase
  end

  // Sign-extend to the datapath width (XLEN >= 32).
  assign imm_o = XLEN'($signed(imm32));

endmodule

// File: rtl/id_stage.sv
// RV32I decode stage: decode, regfile read, EX/MEM forwarding, load-use detection and the
// ID/EX pipeline register with stall, flush and bubble insertion.
module id_stage
  import id_stage_pkg::*;
#(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned PC_W   = 32,
  parameter int unsigned RA_W   = 5,
  parameter bit          FWD_EN = 1'b1
) (
  input  logic            clk,
  input  logic            rst,

  input  logic            if_valid_i,
  input  logic [PC_W-1:0] pc_i,
  input  logic [31:0]     inst_i,

  output logic            reg1_read_o,
  output logic            reg2_read_o,
  output logic [RA_W-1:0] reg1_addr_o,
  output logic [RA_W-1:0] reg2_addr_o,
  input  logic [XLEN-1:0] reg1_data_i,
  input  logic [XLEN-1:0] reg2_data_i,

  input  logic            ex_wreg_i,
  input  logic [RA_W-1:0] ex_wd_i,
  input  logic [XLEN-1:0] ex_wdata_i,
  input  logic            ex_is_load_i,

  input  logic            mem_wreg_i,
  input  logic [RA_W-1:0] mem_wd_i,
  input  logic [XLEN-1:0] mem_wdata_i,

  input  logic            stall_i,
  input  logic            flush_i,
  output logic            stall_req_o,
  output logic            illegal_o,

  output logic            ex_valid_o,
  output logic [PC_W-1:0] ex_pc_o,
  output logic [6:0]      ex_aluop_o,
  output logic [2:0]      ex_alufun_o,
  output logic            ex_f7b_o,
  output logic [XLEN-1:0] ex_reg1_o,
  output logic [XLEN-1:0] ex_reg2_o,
  output logic [XLEN-1:0] ex_imm_o,
  output logic [RA_W-1:0] ex_wd_o,
  output logic            ex_wreg_o,
  output logic            ex_memrd_o,
  output logic            ex_memwr_o
);

  typedef struct packed {
    logic            valid;
    logic [PC_W-1:0] pc;
    logic [6:0]      aluop;
    logic [2:0]      alufun;
    logic            f7b;
    logic [XLEN-1:0] reg1;
    logic [XLEN-1:0] reg2;
    logic [XLEN-1:0] imm;
    logic [RA_W-1:0] wd;
    logic            wreg;
    logic            memrd;
    logic            memwr;
  } idex_t;

  logic [OpcW-1:0] opcode;
  logic [RA_W-1:0] rs1, rs2, rd;
  fmt_e            fmt;
  logic            re1, re2, wreg_raw, memrd, memwr, illegal_op;
  logic [XLEN-1:0] imm;
  logic [XLEN-1:0] op1, op2;
  logic            ld_hit1, ld_hit2;
  idex_t           dec, idex_d, idex_q;

  assign opcode = inst_i[6:0];
  assign rs1    = RA_W'(inst_i[19:15]);
  assign rs2    = RA_W'(inst_i[24:20]);
  assign rd     = RA_W'(inst_i[11:7]);

  always_comb begin
    fmt        = FmtR;
    re1        = 1'b0;
    re2        = 1'b0;
    wreg_raw   = 1'b0;
    memrd      = 1'b0;
    memwr      = 1'b0;
    illegal_op = 1'b0;
    unique case (opcode)
      OpcLui, OpcAuipc: begin
        fmt      = FmtU;
        wreg_raw = WriteEnable;
      end
      OpcJal: begin
        fmt      = FmtJ;
        wreg_raw = WriteEnable;
      end
      OpcJalr, OpcOpImm: begin
        fmt      = FmtI;
        re1      = 1'b1;
        wreg_raw = WriteEnable;
      end
      OpcBranch: begin
        fmt = FmtB;
        re1 = 1'b1;
        re2 = 1'b1;
      end
      OpcLoad: begin
        fmt      = FmtI;
        re1      = 1'b1;
        wreg_raw = WriteEnable;
        memrd    = 1'b1;
      end
      OpcStore: begin
        fmt   = FmtS;
        re1   = 1'b1;
        re2   = 1'b1;
        memwr = 1'b1;
      end
      OpcOp: begin
        fmt      = FmtR;
        re1      = 1'b1;
        re2      = 1'b1;
        wreg_raw = WriteEnable;
      end
      default: illegal_op = 1'b1;
    endcase
  end

  id_stage_imm_gen #(
    .XLEN (XLEN)
  ) u_imm_gen (
    .inst_i (inst_i[31:7]),
    .fmt_i  (fmt),
    .imm_o  (imm)
  );

  assign reg1_read_o = re1;
  assign reg2_read_o = re2;
  assign reg1_addr_o = rs1;
  assign reg2_addr_o = rs2;
  assign illegal_o   = if_valid_i & illegal_op;

  // x0 and disabled ports read as zero; the younger EX result beats MEM.
  function automatic logic [XLEN-1:0] fwd_sel(
    input logic            re,
    input logic [RA_W-1:0] addr,
    input logic [XLEN-1:0] rf_data,
    input logic            exw,
    input logic [RA_W-1:0] exd,
    input logic [XLEN-1:0] exdat,
    input logic            memw,
    input logic [RA_W-1:0] memd,
    input logic [XLEN-1:0] memdat
  );
    if (!re || addr == '0) return '0;
    if (FWD_EN && exw && exd == addr) return exdat;
    if (FWD_EN && memw && memd == addr) return memdat;
    return rf_data;
  endfunction

  always_comb begin
    op1 = fwd_sel(re1, rs1, reg1_data_i, ex_wreg_i, ex_wd_i, ex_wdata_i,
                  mem_wreg_i, mem_wd_i, mem_wdata_i);
    op2 = fwd_sel(re2, rs2, reg2_data_i, ex_wreg_i, ex_wd_i, ex_wdata_i,
                  mem_wreg_i, mem_wd_i, mem_wdata_i);
  end

  // A load in EX cannot be forwarded yet; hold upstream one cycle until it reaches MEM.
  assign ld_hit1     = re1 && (ex_wd_i == rs1);
  assign ld_hit2     = re2 && (ex_wd_i == rs2);
  assign stall_req_o = if_valid_i & ex_is_load_i & ex_wreg_i & (ex_wd_i != '0) &
                       (ld_hit1 | ld_hit2);

  always_comb begin
    dec        = '0;
    dec.valid  = 1'b1;
    dec.pc     = pc_i;
    dec.aluop  = opcode;
    dec.alufun = inst_i[14:12];
    dec.f7b    = inst_i[30];
    dec.reg1   = op1;
    dec.reg2   = op2;
    dec.imm    = imm;
    dec.wd     = rd;
    dec.wreg   = wreg_raw & (rd != '0);
    dec.memrd  = memrd;
    dec.memwr  = memwr;
  end

  always_comb begin
    idex_d = idex_q;
    if (flush_i) begin
      idex_d = '0;
    end else if (stall_i) begin
      idex_d = idex_q;
    end else if (stall_req_o) begin
      idex_d = '0;
    end else if (if_valid_i && !illegal_o) begin
      idex_d = dec;
    end else begin
      idex_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      idex_q <= '0;
    end else begin
      idex_q <= idex_d;
    end
  end

  assign ex_valid_o  = idex_q.valid;
  assign ex_pc_o     = idex_q.pc;
  assign ex_aluop_o  = idex_q.aluop;
  assign ex_alufun_o = idex_q.alufun;
  assign ex_f7b_o    = idex_q.f7b;
  assign ex_reg1_o   = idex_q.reg1;
  assign ex_reg2_o   = idex_q.reg2;
  assign ex_imm_o    = idex_q.imm;
  assign ex_wd_o     = idex_q.wd;
  assign ex_wreg_o   = idex_q.wreg;
  assign ex_memrd_o  = idex_q.memrd;
  assign ex_memwr_o  = idex_q.memwr;

endmodule

// File: tb/tb_id_stage.sv
// Bench for id_stage: vector table through a forwarding and a non-forwarding instance,
// expected ID/EX contents queued at drive time and compared one cycle later.
module tb_id_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_valid_i;
  logic [31:0] pc_i, inst_i, reg1_data_i, reg2_data_i;
  logic        ex_wreg_i, ex_is_load_i, mem_wreg_i;
  logic [4:0]  ex_wd_i, mem_wd_i;
  logic [31:0] ex_wdata_i, mem_wdata_i;
  logic        stall_i, flush_i;

  logic        reg1_read, reg2_read, stall_req, illegal;
  logic [4:0]  reg1_addr, reg2_addr, ex_wd;
  logic        ex_valid, ex_f7b, ex_wreg, ex_memrd, ex_memwr;
  logic [31:0] ex_pc, ex_reg1, ex_reg2, ex_imm;
  logic [6:0]  ex_aluop;
  logic [2:0]  ex_alufun;

  logic        nf_reg1_read, nf_reg2_read, nf_stall_req, nf_illegal;
  logic [4:0]  nf_reg1_addr, nf_reg2_addr, nf_ex_wd;
  logic        nf_ex_valid, nf_ex_f7b, nf_ex_wreg, nf_ex_memrd, nf_ex_memwr;
  logic [31:0] nf_ex_pc, nf_ex_reg1, nf_ex_reg2, nf_ex_imm;
  logic [6:0]  nf_ex_aluop;
  logic [2:0]  nf_ex_alufun;

  always #5 clk = ~clk;

  id_stage #(.XLEN(32), .PC_W(32), .RA_W(5), .FWD_EN(1'b1)) u_dut (
    .clk(clk), .rst(rst), .if_valid_i(if_valid_i), .pc_i(pc_i), .inst_i(inst_i),
    .reg1_read_o(reg1_read), .reg2_read_o(reg2_read),
    .reg1_addr_o(reg1_addr), .reg2_addr_o(reg2_addr),
    .reg1_data_i(reg1_data_i), .reg2_data_i(reg2_data_i),
    .ex_wreg_i(ex_wreg_i), .ex_wd_i(ex_wd_i), .ex_wdata_i(ex_wdata_i),
    .ex_is_load_i(ex_is_load_i),
    .mem_wreg_i(mem_wreg_i), .mem_wd_i(mem_wd_i), .mem_wdata_i(mem_wdata_i),
    .stall_i(stall_i), .flush_i(flush_i), .stall_req_o(stall_req), .illegal_o(illegal),
    .ex_valid_o(ex_valid), .ex_pc_o(ex_pc), .ex_aluop_o(ex_aluop), .ex_alufun_o(ex_alufun),
    .ex_f7b_o(ex_f7b), .ex_reg1_o(ex_reg1), .ex_reg2_o(ex_reg2), .ex_imm_o(ex_imm),
    .ex_wd_o(ex_wd), .ex_wreg_o(ex_wreg), .ex_memrd_o(ex_memrd), .ex_memwr_o(ex_memwr)
  );

  id_stage #(.XLEN(32), .PC_W(32), .RA_W(5), .FWD_EN(1'b0)) u_dut_nf (
    .clk(clk), .rst(rst), .if_valid_i(if_valid_i), .pc_i(pc_i), .inst_i(inst_i),
    .reg1_read_o(nf_reg1_read), .reg2_read_o(nf_reg2_read),
    .reg1_addr_o(nf_reg1_addr), .reg2_addr_o(nf_reg2_addr),
    .reg1_data_i(reg1_data_i), .reg2_data_i(reg2_data_i),
    .ex_wreg_i(ex_wreg_i), .ex_wd_i(ex_wd_i), .ex_wdata_i(ex_wdata_i),
    .ex_is_load_i(ex_is_load_i),
    .mem_wreg_i(mem_wreg_i), .mem_wd_i(mem_wd_i), .mem_wdata_i(mem_wdata_i),
    .stall_i(stall_i), .flush_i(flush_i), .stall_req_o(nf_stall_req), .illegal_o(nf_illegal),
    .ex_valid_o(nf_ex_valid), .ex_pc_o(nf_ex_pc), .ex_aluop_o(nf_ex_aluop),
    .ex_alufun_o(nf_ex_alufun), .ex_f7b_o(nf_ex_f7b), .ex_reg1_o(nf_ex_reg1),
    .ex_reg2_o(nf_ex_reg2), .ex_imm_o(nf_ex_imm), .ex_wd_o(nf_ex_wd), .ex_wreg_o(nf_ex_wreg),
    .ex_memrd_o(nf_ex_memrd), .ex_memwr_o(nf_ex_memwr)
  );

  typedef struct packed {
    logic        rst, ifv, stall, flush;
    logic [31:0] inst;
    logic        exw;
    logic [4:0]  exd;
    logic [31:0] exdat;
    logic        exld;
    logic        mw;
    logic [4:0]  md;
    logic [31:0] mdat;
    logic [31:0] r1, r2;
    // expected decode of this row
    logic [1:0]  e_re;
    logic        e_stall, e_ill;
    logic [31:0] e_imm, e_op1, e_op2, e_op1n, e_op2n;
    logic [4:0]  e_wd;
    logic        e_wreg, e_rd, e_wr;
  } vec_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [6:0]  aluop;
    logic [2:0]  fun;
    logic        f7b;
    logic [31:0] op1, op2, op1n, op2n, imm;
    logic [4:0]  wd;
    logic        wreg, rd, wr;
  } out_t;

  localparam int NVec = 22;
  vec_t vecs [NVec];
  out_t exp_q[$];
  out_t last_exp;
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic chk(input string nm, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s vec %0d: got %h expected %h", nm, idx, act, exp);
    end
  endtask

  task automatic apply(input vec_t v, input int idx);
    out_t e;
    rst          = v.rst;
    if_valid_i   = v.ifv;
    stall_i      = v.stall;
    flush_i      = v.flush;
    inst_i       = v.inst;
    pc_i         = 32'h1000 + 32'(idx * 4);
    ex_wreg_i    = v.exw;
    ex_wd_i      = v.exd;
    ex_wdata_i   = v.exdat;
    ex_is_load_i = v.exld;
    mem_wreg_i   = v.mw;
    mem_wd_i     = v.md;
    mem_wdata_i  = v.mdat;
    reg1_data_i  = v.r1;
    reg2_data_i  = v.r2;
    #1;
    chk("stall_req", idx, 32'(stall_req), 32'(v.e_stall));
    chk("stall_req_nf", idx, 32'(nf_stall_req), 32'(v.e_stall));
    chk("illegal", idx, 32'(illegal), 32'(v.e_ill));
    chk("read_en", idx, 32'({reg1_read, reg2_read}), 32'(v.e_re));
    chk("reg1_addr", idx, 32'(reg1_addr), 32'(v.inst[19:15]));
    chk("reg2_addr", idx, 32'(reg2_addr), 32'(v.inst[24:20]));

    e = '0;
    if (v.rst || v.flush) begin
      e = '0;
    end else if (v.stall) begin
      e = last_exp;
    end else if (v.e_stall || !v.ifv || v.e_ill) begin
      e = '0;
    end else begin
      e.valid = 1'b1;
      e.pc    = pc_i;
      e.aluop = v.inst[6:0];
      e.fun   = v.inst[14:12];
      e.f7b   = v.inst[30];
      e.op1   = v.e_op1;
      e.op2   = v.e_op2;
      e.op1n  = v.e_op1n;
      e.op2n  = v.e_op2n;
      e.imm   = v.e_imm;
      e.wd    = v.e_wd;
      e.wreg  = v.e_wreg;
      e.rd    = v.e_rd;
      e.wr    = v.e_wr;
    end
    last_exp = e;
    exp_q.push_back(e);

    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    chk("ex_valid", idx, 32'(ex_valid), 32'(e.valid));
    chk("ex_pc", idx, ex_pc, e.pc);
    chk("ex_aluop", idx, 32'(ex_aluop), 32'(e.aluop));
    chk("ex_alufun", idx, 32'(ex_alufun), 32'(e.fun));
    chk("ex_f7b", idx, 32'(ex_f7b), 32'(e.f7b));
    chk("ex_reg1", idx, ex_reg1, e.op1);
    chk("ex_reg2", idx, ex_reg2, e.op2);
    chk("ex_reg1_nofwd", idx, nf_ex_reg1, e.op1n);
    chk("ex_reg2_nofwd", idx, nf_ex_reg2, e.op2n);
    chk("ex_imm", idx, ex_imm, e.imm);
    chk("ex_wd", idx, 32'(ex_wd), 32'(e.wd));
    chk("ex_wreg", idx, 32'(ex_wreg), 32'(e.wreg));
    chk("ex_memrd", idx, 32'(ex_memrd), 32'(e.rd));
    chk("ex_memwr", idx, 32'(ex_memwr), 32'(e.wr));
  endtask

  initial begin
    // reset with an addi presented
    vecs[0]  = '{default: '0, rst: 1'b1, ifv: 1'b1, inst: 32'hFFB00093, e_re: 2'b10};
    // addi x1,x0,-5
    vecs[1]  = '{default: '0, ifv: 1'b1, inst: 32'hFFB00093, r1: 32'hAAAA, r2: 32'hBBBB,
                 e_re: 2'b10, e_imm: 32'hFFFFFFFB, e_wd: 5'd1, e_wreg: 1'b1};
    // beq x1,x2,-8
    vecs[2]  = '{default: '0, ifv: 1'b1, inst: 32'hFE208CE3, r1: 32'h10, r2: 32'h20,
                 e_re: 2'b11, e_imm: 32'hFFFFFFF8, e_op1: 32'h10, e_op2: 32'h20,
                 e_op1n: 32'h10, e_op2n: 32'h20, e_wd: 5'd25};
    // jal x1,+2048
    vecs[3]  = '{default: '0, ifv: 1'b1, inst: 32'h001000EF, r1: 32'h55, r2: 32'h66,
                 e_imm: 32'h800, e_wd: 5'd1, e_wreg: 1'b1};
    // add x3,x1,x2: EX and MEM both target x1, EX wins
    vecs[4]  = '{default: '0, ifv: 1'b1, inst: 32'h002081B3, exw: 1'b1, exd: 5'd1,
                 exdat: 32'h11, mw: 1'b1, md: 5'd1, mdat: 32'h22, r1: 32'h44, r2: 32'h33,
                 e_re: 2'b11, e_op1: 32'h11, e_op2: 32'h33, e_op1n: 32'h44, e_op2n: 32'h33,
                 e_wd: 5'd3, e_wreg: 1'b1};
    // add x3,x1,x2: EX not writing, MEM forwards x2
    vecs[5]  = '{default: '0, ifv: 1'b1, inst: 32'h002081B3, exd: 5'd2, exdat: 32'h77,
                 mw: 1'b1, md: 5'd2, mdat: 32'h22, r1: 32'h44, r2: 32'h33,
                 e_re: 2'b11, e_op1: 32'h44, e_op2: 32'h22, e_op1n: 32'h44, e_op2n: 32'h33,
                 e_wd: 5'd3, e_wreg: 1'b1};
    // sw x2,12(x1)
    vecs[6]  = '{default: '0, ifv: 1'b1, inst: 32'h0020A623, r1: 32'h100, r2: 32'h200,
                 e_re: 2'b11, e_imm: 32'hC, e_op1: 32'h100, e_op2: 32'h200,
                 e_op1n: 32'h100, e_op2n: 32'h200, e_wd: 5'd12, e_wr: 1'b1};
    // lw x5,-4(x1)
    vecs[7]  = '{default: '0, ifv: 1'b1, inst: 32'hFFC0A283, r1: 32'h100, r2: 32'h200,
                 e_re: 2'b10, e_imm: 32'hFFFFFFFC, e_op1: 32'h100, e_op1n: 32'h100,
                 e_wd: 5'd5, e_wreg: 1'b1, e_rd: 1'b1};
    // lui x0,0x12345: valid but no write
    vecs[8]  = '{default: '0, ifv: 1'b1, inst: 32'h12345037, e_imm: 32'h12345000};
    // unknown opcode
    vecs[9]  = '{default: '0, ifv: 1'b1, inst: 32'h0000007F, e_ill: 1'b1};
    // auipc x7,0xFFFFF
    vecs[10] = '{default: '0, ifv: 1'b1, inst: 32'hFFFFF397, e_imm: 32'hFFFFF000,
                 e_wd: 5'd7, e_wreg: 1'b1};
    // addi with if_valid low: bubble
    vecs[11] = '{default: '0, inst: 32'hFFB00093, r1: 32'hAAAA, e_re: 2'b10};
    // jalr x1,16(x2)
    vecs[12] = '{default: '0, ifv: 1'b1, inst: 32'h010100E7, r1: 32'h3000,
                 e_re: 2'b10, e_imm: 32'h10, e_op1: 32'h3000, e_op1n: 32'h3000,
                 e_wd: 5'd1, e_wreg: 1'b1};
    // addi, then stall_i held three cycles while a different inst is presented
    vecs[13] = vecs[1];
    for (int i = 14; i < 17; i++) begin
      vecs[i] = '{default: '0, ifv: 1'b1, stall: 1'b1, inst: 32'h002081B3, r1: 32'h44,
                  r2: 32'h33, e_re: 2'b11, e_op1: 32'h44, e_op2: 32'h33, e_op1n: 32'h44,
                  e_op2n: 32'h33, e_wd: 5'd3, e_wreg: 1'b1};
    end
    // flush and stall together: flush wins
    vecs[17] = vecs[16];
    vecs[17].flush = 1'b1;
    // load-use: lw x5 in EX, add x6,x5,x0 in ID
    vecs[18] = '{default: '0, ifv: 1'b1, inst: 32'h00028333, exw: 1'b1, exd: 5'd5,
                 exdat: 32'hDEAD, exld: 1'b1, r1: 32'h1234, e_re: 2'b11, e_stall: 1'b1,
                 e_op1: 32'hDEAD, e_op1n: 32'h1234, e_wd: 5'd6, e_wreg: 1'b1};
    // load now in MEM
    vecs[19] = '{default: '0, ifv: 1'b1, inst: 32'h00028333, mw: 1'b1, md: 5'd5,
                 mdat: 32'h99, r1: 32'h1234, e_re: 2'b11, e_op1: 32'h99, e_op1n: 32'h1234,
                 e_wd: 5'd6, e_wreg: 1'b1};
    // reset during a load-use stall
    vecs[20] = vecs[18];
    vecs[20].rst = 1'b1;
    vecs[21] = vecs[1];

    rst          = 1'b1;
    if_valid_i   = 1'b0;
    stall_i      = 1'b0;
    flush_i      = 1'b0;
    inst_i       = '0;
    pc_i         = '0;
    ex_wreg_i    = 1'b0;
    ex_wd_i      = '0;
    ex_wdata_i   = '0;
    ex_is_load_i = 1'b0;
    mem_wreg_i   = 1'b0;
    mem_wd_i     = '0;
    mem_wdata_i  = '0;
    reg1_data_i  = '0;
    reg2_data_i  = '0;
    last_exp     = '0;
    @(posedge clk);
    #1;

    for (int i = 0; i < NVec; i++) begin
      apply(vecs[i], i);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
